// File: rtl/instance_norm_pkg.sv
// -----------------------------------------------------------------------------
// instance_norm_pkg
// Shared definitions for the instance-normalisation statistics block:
//   - state_t       : control FSM states (ACCUM, FINAL, HOLD)
//   - DEF_DATA_W    : default signed sample width
//   - DEF_N_LOG2    : default log2 of samples per instance
//   - DEF_SUM_W / DEF_SUMSQ_W and sum_width()/sumsq_width(): accumulator widths
// -----------------------------------------------------------------------------
package instance_norm_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FINAL = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_N_LOG2 = 10;

   // Signed sum of N samples needs N_LOG2 guard bits; the sum of squares
   // likewise grows by N_LOG2 bits over a single 2*DATA_W square.
   localparam int DEF_SUM_W   = DEF_DATA_W + DEF_N_LOG2;
   localparam int DEF_SUMSQ_W = 2 * DEF_DATA_W + DEF_N_LOG2;

   function automatic int sum_width(input int data_w, input int n_log2);
      return data_w + n_log2;
   endfunction

   function automatic int sumsq_width(input int data_w, input int n_log2);
      return 2 * data_w + n_log2;
   endfunction

endpackage

// File: rtl/instance_norm_acc.sv
// -----------------------------------------------------------------------------
// instance_norm_acc
// Running sum / sum-of-squares / sample-count registers for one instance.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of all accumulators (wins over acc_en)
//   acc_en     : add 'sample' into the accumulators this cycle
//   sample     : signed input sample
//   sum        : signed running sum            (DATA_W+N_LOG2 bits)
//   sumsq      : unsigned running sum of sq.   (2*DATA_W+N_LOG2 bits)
//   count      : samples accepted, wraps at N  (N_LOG2 bits)
// -----------------------------------------------------------------------------
module instance_norm_acc
   import instance_norm_pkg::*;
#(
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int N_LOG2  = DEF_N_LOG2,
   localparam int SUM_W   = sum_width(DATA_W, N_LOG2),
   localparam int SUMSQ_W = sumsq_width(DATA_W, N_LOG2)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      acc_en,
   input  logic signed [DATA_W-1:0]  sample,
   output logic signed [SUM_W-1:0]   sum,
   output logic [SUMSQ_W-1:0]        sumsq,
   output logic [N_LOG2-1:0]         count
);

   logic signed [2*DATA_W-1:0] sample_x;
   logic signed [2*DATA_W-1:0] sample_sq;

   // The square of a DATA_W signed value is at most 2^(2*DATA_W-2), so it
   // is always non-negative within 2*DATA_W bits and can be zero-extended.
   always_comb begin
      sample_x  = {{DATA_W{sample[DATA_W-1]}}, sample};
      sample_sq = sample_x * sample_x;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= '0;
         sumsq <= '0;
         count <= '0;
      end else if (clr) begin
         sum   <= '0;
         sumsq <= '0;
         count <= '0;
      end else if (acc_en) begin
         sum   <= sum + $signed({{N_LOG2{sample[DATA_W-1]}}, sample});
         sumsq <= sumsq + {{N_LOG2{1'b0}}, sample_sq};
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/instance_norm_stats.sv
// -----------------------------------------------------------------------------
// instance_norm_stats
// Collects N = 2^N_LOG2 signed samples per instance and produces the mean and
// the (clamped, non-negative) variance E[x^2] - mean^2 for a downstream
// normalizer. Instance boundaries are set by the sample count only; in_last
// is merely cross-checked and disagreements are reported through len_err.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_in    : sample valid           ready_in : block can accept (registered)
//   input_data  : signed sample, Q(DATA_W/2).(DATA_W/2)
//   in_last     : producer's last-sample marker, qualified by the accept
//   valid_out   : statistics valid       ready_out: consumer takes statistics
//   mean_out    : signed mean, same format as input_data (floor)
//   var_out     : unsigned variance, Q(DATA_W).(DATA_W)
//   len_err     : in_last disagreed with the count, qualified by valid_out
// -----------------------------------------------------------------------------
module instance_norm_stats
   import instance_norm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_LOG2 = DEF_N_LOG2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   output logic                 ready_in,
   input  logic [DATA_W-1:0]    input_data,
   input  logic                 in_last,
   output logic                 valid_out,
   input  logic                 ready_out,
   output logic [DATA_W-1:0]    mean_out,
   output logic [2*DATA_W-1:0]  var_out,
   output logic                 len_err
);

   localparam int SUM_W   = sum_width(DATA_W, N_LOG2);
   localparam int SUMSQ_W = sumsq_width(DATA_W, N_LOG2);
   localparam int VAR_W   = 2 * DATA_W;
   localparam logic [N_LOG2-1:0] LAST_CNT = '1;

   state_t state;
   state_t state_next;

   logic                      accept;
   logic                      last_slot;
   logic                      load_stats;
   logic                      clr_acc;
   logic                      err;
   logic                      err_next;

   logic signed [SUM_W-1:0]   sum;
   logic [SUMSQ_W-1:0]        sumsq;
   logic [N_LOG2-1:0]         count;

   logic signed [DATA_W-1:0]  mean_c;
   logic [VAR_W-1:0]          ex2_c;
   logic signed [VAR_W-1:0]   mean_x;
   logic signed [VAR_W-1:0]   mean_sq;
   logic [VAR_W-1:0]          var_c;

   // Rounding of E[x^2] - mean^2 can push the difference slightly below zero
   // (e.g. a floored negative mean); a variance is never negative.
   function automatic logic [VAR_W-1:0] clamp_var(input logic signed [VAR_W:0] diff);
      return diff[VAR_W] ? '0 : diff[VAR_W-1:0];
   endfunction

   instance_norm_acc #(
      .DATA_W (DATA_W),
      .N_LOG2 (N_LOG2)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_acc),
      .acc_en (accept),
      .sample ($signed(input_data)),
      .sum    (sum),
      .sumsq  (sumsq),
      .count  (count)
   );

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      load_stats = 1'b0;
      clr_acc    = 1'b0;
      case (state)
         ST_ACCUM: begin
            accept = valid_in;
            if (valid_in && (count == LAST_CNT)) begin
               state_next = ST_FINAL;
            end
         end
         ST_FINAL: begin
            load_stats = 1'b1;
            state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (ready_out) begin
               clr_acc    = 1'b1;
               state_next = ST_ACCUM;
            end
         end
         default: state_next = ST_ACCUM;
      endcase
   end

   always_comb begin
      last_slot = (count == LAST_CNT);
      if (clr_acc) begin
         err_next = 1'b0;
      end else begin
         err_next = err | (accept & (in_last ^ last_slot));
      end
   end

   // FINAL stage: the accumulators already hold all N samples here
   always_comb begin
      mean_c  = DATA_W'(sum >>> N_LOG2);
      ex2_c   = VAR_W'(sumsq >> N_LOG2);
      mean_x  = {{DATA_W{mean_c[DATA_W-1]}}, mean_c};
      mean_sq = mean_x * mean_x;
      var_c   = clamp_var($signed({1'b0, ex2_c}) - $signed({1'b0, mean_sq}));
   end

   // ready_in / valid_out are registered from the next state, so ready_out
   // never reaches ready_in combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         ready_in  <= 1'b1;
         valid_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_next;
         ready_in  <= (state_next == ST_ACCUM);
         valid_out <= (state_next == ST_HOLD);
         err       <= err_next;
      end
   end

   // Result registers: loaded once in FINAL, stable through HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mean_out <= '0;
         var_out  <= '0;
         len_err  <= 1'b0;
      end else if (load_stats) begin
         mean_out <= mean_c;
         var_out  <= var_c;
         len_err  <= err;
      end
   end

endmodule

// File: tb/tb_instance_norm_stats.sv
// -----------------------------------------------------------------------------
// tb_instance_norm_stats
// Bench for instance_norm_stats with DATA_W=16, N_LOG2=2 (4 samples/instance).
// A behavioural model tracks accepted samples and instance phase; a compare
// process checks the DUT against it on every falling edge. Directed cases pin
// literal results; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instance_norm_stats;

   localparam int DW = 16;
   localparam int NL = 2;
   localparam int N  = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           valid_in;
   logic           ready_in;
   logic [DW-1:0]  input_data;
   logic           in_last;
   logic           valid_out;
   logic           ready_out;
   logic [DW-1:0]  mean_out;
   logic [2*DW-1:0] var_out;
   logic           len_err;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   instance_norm_stats #(
      .DATA_W (DW),
      .N_LOG2 (NL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .input_data (input_data),
      .in_last    (in_last),
      .valid_out  (valid_out),
      .ready_out  (ready_out),
      .mean_out   (mean_out),
      .var_out    (var_out),
      .len_err    (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // stage: 0 = collecting samples, 1 = the computing cycle, 2 = results held
   int      stage = 0;
   int      m_cnt = 0;
   longint  m_sum = 0;
   longint  m_sq  = 0;
   bit      m_err = 1'b0;
   longint  s_val, mean_v, ex2_v, var_v;
   logic [DW-1:0]   e_mean = '0;
   logic [2*DW-1:0] e_var  = '0;
   bit              e_err  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage = 0; m_cnt = 0; m_sum = 0; m_sq = 0; m_err = 1'b0;
      end else begin
         case (stage)
            0: if (valid_in) begin
               s_val = longint'($signed(input_data));
               m_sum += s_val;
               m_sq  += s_val * s_val;
               if (in_last != (m_cnt == N - 1)) m_err = 1'b1;
               if (m_cnt == N - 1) begin
                  mean_v = m_sum >>> NL;
                  ex2_v  = m_sq / N;
                  var_v  = ex2_v - mean_v * mean_v;
                  if (var_v < 0) var_v = 0;
                  e_mean = mean_v[DW-1:0];
                  e_var  = var_v[2*DW-1:0];
                  e_err  = m_err;
                  stage = 1; m_cnt = 0; m_sum = 0; m_sq = 0; m_err = 1'b0;
               end else begin
                  m_cnt++;
               end
            end
            1: stage = 2;
            default: if (ready_out) stage = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         if (!rst_n) begin
            chk("rst_ready_in", ready_in, 1);
            chk("rst_valid_out", valid_out, 0);
            chk("rst_mean", mean_out, 0);
            chk("rst_var", var_out, 0);
            chk("rst_len_err", len_err, 0);
         end else begin
            chk("ready_in", ready_in, stage == 0);
            chk("valid_out", valid_out, stage == 2);
            if (stage == 2) begin
               chk("mean_out", mean_out, e_mean);
               chk("var_out", var_out, e_var);
               chk("len_err", len_err, e_err);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic put(input logic [DW-1:0] d, input logic l);
      valid_in   = 1'b1;
      input_data = d;
      in_last    = l;
      @(posedge clk); #1;
      valid_in   = 1'b0;
      in_last    = 1'b0;
      input_data = 16'($urandom);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!valid_out && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("valid_wait", valid_out, 1);
   endtask

   task automatic handshake();
      ready_out = 1'b1;
      @(posedge clk); #1;
      ready_out = 1'b0;
      chk("hs_ready_in", ready_in, 1);
      chk("hs_valid_out", valid_out, 0);
   endtask

   task automatic pin(input string nm, input logic [DW-1:0] em,
                      input logic [2*DW-1:0] ev, input logic ee);
      chk({nm, "_valid"}, valid_out, 1);
      chk({nm, "_mean"}, mean_out, em);
      chk({nm, "_var"}, var_out, ev);
      chk({nm, "_len_err"}, len_err, ee);
   endtask

   // Four back-to-back samples; lastbits[i] drives in_last on sample i.
   task automatic run4(input string nm, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic [3:0] lastbits,
                       input logic [DW-1:0] em, input logic [2*DW-1:0] ev, input logic ee);
      put(d0, lastbits[0]);
      put(d1, lastbits[1]);
      put(d2, lastbits[2]);
      put(d3, lastbits[3]);
      chk({nm, "_final_valid"}, valid_out, 0);
      @(posedge clk); #1;
      pin(nm, em, ev, ee);
      handshake();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b1;
      valid_in   = 1'b0;
      in_last    = 1'b0;
      input_data = '0;
      ready_out  = 1'b0;
      #2 rst_n = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready_in", ready_in, 1);
      chk("reset_valid_out", valid_out, 0);
      chk("reset_mean", mean_out, 0);
      chk("reset_var", var_out, 0);
      rst_n = 1'b1;

      run4("const", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b1000, 16'h0100, 32'h0, 1'b0);
      run4("alt", 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 4'b1000, 16'h0000, 32'h00010000, 1'b0);
      run4("floor", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 16'hFFFF, 32'h0, 1'b0);

      // Backpressure in HOLD with ignored input pulses
      put(16'h0300, 1'b0);
      put(16'h0100, 1'b0);
      put(16'h0300, 1'b0);
      put(16'h0100, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         valid_in   = 1'b1;
         in_last    = 1'b1;
         input_data = 16'($urandom);
         @(posedge clk); #1;
         pin("hold", 16'h0200, 32'h00010000, 1'b0);
         chk("hold_ready_in", ready_in, 0);
      end
      valid_in = 1'b0;
      in_last  = 1'b0;
      handshake();
      run4("after_hold", 16'h0040, 16'h0040, 16'h0040, 16'h0040, 4'b1000, 16'h0040, 32'h0, 1'b0);

      run4("early_last", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0010, 16'h0100, 32'h0, 1'b1);
      run4("err_cleared", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b1000, 16'h0100, 32'h0, 1'b0);

      // Reset mid-instance
      put(16'h1234, 1'b0);
      put(16'h5678, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready_in", ready_in, 1);
      chk("midrst_valid_out", valid_out, 0);
      chk("midrst_mean", mean_out, 0);
      chk("midrst_var", var_out, 0);
      chk("midrst_len_err", len_err, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run4("post_rst", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 4'b1000, 16'h0200, 32'h0, 1'b0);

      // Randomized instances with gaps, extremes, wrong in_last and stalls
      for (int inst = 0; inst < 40; inst++) begin
         for (int i = 0; i < N; i++) begin
            logic [DW-1:0] d;
            int r;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            r = $urandom_range(0, 9);
            if (r == 0)      d = 16'h8000;
            else if (r == 1) d = 16'h7FFF;
            else             d = 16'($urandom);
            put(d, (i == N - 1) ^ ($urandom_range(0, 9) == 0));
         end
         wait_valid();
         repeat ($urandom_range(0, 3)) begin
            valid_in = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         valid_in = 1'b0;
         in_last  = 1'b0;
         handshake();
      end

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
